// File: rtl/cpu_thread_sched.sv
// rtl/cpu_thread_sched.sv - round-robin hardware thread scheduler with per-thread saved IPs
//
// Optional feature macro: CPU_IDLE_COUNTER_EN
//   defined   -> idle_cycles counts non-RUN cycles, saturating at 16'hFFFF
//   undefined -> idle_cycles is tied to zero
//
// The scheduler owns one saved instruction pointer per thread (ip_mem) and
// the live fetch pointer (ip_curr).  A thread runs until the execute stage
// asks for a switch; its resume IP is then written back to ip_mem and the
// next ready thread is chosen round-robin, the current thread checked last.

module cpu_thread_sched #(
  parameter int N_THREADS     = 4,
  parameter int N_THREADS_MSB = 1,
  parameter int IP_WIDTH      = 9
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [N_THREADS-1:0]     thread_ready,
  input  logic                     exec_switch,
  input  logic [IP_WIDTH-1:0]      exec_ip_next,
  input  logic                     exec_jump,
  input  logic [IP_WIDTH-1:0]      jump_ip,
  input  logic                     instr_advance,
  input  logic                     thread_almost_switched,
  input  logic                     thread_ip_wr,
  input  logic [N_THREADS_MSB:0]   thread_ip_wr_num,
  input  logic [IP_WIDTH-1:0]      thread_ip_wr_data,
  output logic                     thread_ip_wr_ready,
  output logic                     reload,
  output logic                     invalidate,
  output logic [IP_WIDTH-1:0]      ip_curr,
  output logic [N_THREADS_MSB:0]   thread_num,
  output logic [N_THREADS_MSB:0]   thread_num_exec,
  output logic                     thread_active,
  output logic [15:0]              idle_cycles
);

  localparam int TW = N_THREADS_MSB + 1;

  typedef enum logic [1:0] {
    S_SELECT = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Saved IP per thread; a single write port shared by switch-save and
  // the external writer, read asynchronously during LOAD.
  logic [IP_WIDTH-1:0] ip_mem [N_THREADS];

  // After reset the first pick scans from thread 0 rather than thread_num+1.
  logic first_sel;

  // Round-robin pick
  logic          pick_valid;
  logic [TW-1:0] pick_idx;
  logic [TW-1:0] search_base;
  logic [TW-1:0] cand;

  // Qualified execute-stage requests
  logic act_switch;
  logic act_jump;
  logic act_adv;

  // Next values for the registered outputs
  logic                reload_d;
  logic                invalidate_d;
  logic [IP_WIDTH-1:0] ip_curr_d;
  logic [TW-1:0]       thread_num_d;
  logic                first_sel_d;

  // RAM write enables
  logic save_we;
  logic ext_we;

  // Search forward from the thread after the current one; iterating from the
  // far end down lets the nearest ready thread overwrite earlier candidates.
  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = '0;
    cand        = '0;
    search_base = first_sel ? '0 : thread_num + 1'b1;
    for (int i = N_THREADS - 1; i >= 0; i--) begin
      cand = search_base + TW'(i);
      if (thread_ready[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Execute-stage requests only act in RUN and never during an invalidate
  // cycle; switch outranks jump, which outranks a plain advance.  A reload
  // cycle also suppresses advance because fetch has not consumed ip_curr yet.
  always_comb begin
    act_switch = (state == S_RUN) && exec_switch && !invalidate;
    act_jump   = (state == S_RUN) && exec_jump && !exec_switch && !invalidate;
    act_adv    = (state == S_RUN) && instr_advance && !exec_switch && !exec_jump
                 && !invalidate && !reload;
  end

  // The save port has priority over the external writer, so the writer is
  // stalled whenever a switch could claim the RAM this cycle.
  assign thread_ip_wr_ready = !((state == S_RUN) && exec_switch);
  assign save_we            = act_switch;
  assign ext_we             = thread_ip_wr && thread_ip_wr_ready;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= S_SELECT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_SELECT: if (pick_valid) state_next = S_LOAD;
      S_LOAD:   state_next = S_RUN;
      S_RUN:    if (act_switch) state_next = S_SELECT;
      default:  state_next = S_SELECT;
    endcase
  end

  // FSM output logic: next values of fetch IP, thread number and pulses.
  // A jump's invalidate cycle is the only invalidate seen while still in
  // RUN (a switch's invalidate lands in SELECT), so it alone chains a reload.
  always_comb begin
    ip_curr_d    = ip_curr;
    thread_num_d = thread_num;
    first_sel_d  = first_sel;
    invalidate_d = act_switch || act_jump;
    reload_d     = (state == S_LOAD) || (invalidate && (state == S_RUN));
    case (state)
      S_SELECT: begin
        if (pick_valid) begin
          thread_num_d = pick_idx;
          first_sel_d  = 1'b0;
        end
      end
      S_LOAD: begin
        ip_curr_d = ip_mem[thread_num];
      end
      S_RUN: begin
        if (act_jump) begin
          ip_curr_d = jump_ip;
        end else if (act_adv) begin
          ip_curr_d = ip_curr + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and scheduler bookkeeping
  always_ff @(posedge CLK) begin
    if (reset) begin
      reload        <= 1'b0;
      invalidate    <= 1'b0;
      ip_curr       <= '0;
      thread_num    <= '0;
      thread_active <= 1'b0;
      first_sel     <= 1'b1;
    end else begin
      reload        <= reload_d;
      invalidate    <= invalidate_d;
      ip_curr       <= ip_curr_d;
      thread_num    <= thread_num_d;
      thread_active <= (state_next == S_RUN);
      first_sel     <= first_sel_d;
    end
  end

  // Execute-stage thread number trails fetch by the tracker's switch timing
  always_ff @(posedge CLK) begin
    if (reset) begin
      thread_num_exec <= '0;
    end else if (thread_almost_switched) begin
      thread_num_exec <= thread_num;
    end
  end

  // Saved-IP RAM; deliberately untouched by reset so an aborted thread
  // keeps whatever was last stored for it.
  always_ff @(posedge CLK) begin
    if (save_we) begin
      ip_mem[thread_num] <= exec_ip_next;
    end else if (ext_we) begin
      ip_mem[thread_ip_wr_num] <= thread_ip_wr_data;
    end
  end

`ifdef CPU_IDLE_COUNTER_EN
  logic [15:0] idle_cnt;

  // Saturating count of cycles spent outside RUN
  always_ff @(posedge CLK) begin
    if (reset) begin
      idle_cnt <= 16'd0;
    end else if ((state != S_RUN) && (idle_cnt != 16'hFFFF)) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign idle_cycles = idle_cnt;
`else
  assign idle_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_thread_sched.sv
// tb/tb_cpu_thread_sched.sv - directed scoreboard bench for cpu_thread_sched

module tb_cpu_thread_sched;

  logic        CLK = 1'b0;
  logic        reset;
  logic [3:0]  thread_ready;
  logic        exec_switch;
  logic [8:0]  exec_ip_next;
  logic        exec_jump;
  logic [8:0]  jump_ip;
  logic        instr_advance;
  logic        thread_almost_switched;
  logic        thread_ip_wr;
  logic [1:0]  thread_ip_wr_num;
  logic [8:0]  thread_ip_wr_data;
  logic        thread_ip_wr_ready;
  logic        reload;
  logic        invalidate;
  logic [8:0]  ip_curr;
  logic [1:0]  thread_num;
  logic [1:0]  thread_num_exec;
  logic        thread_active;
  logic [15:0] idle_cycles;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] tn;
    logic [8:0] ip;
  } exp_t;

  exp_t sb[$];

  cpu_thread_sched #(
    .N_THREADS(4),
    .N_THREADS_MSB(1),
    .IP_WIDTH(9)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .thread_ready(thread_ready),
    .exec_switch(exec_switch),
    .exec_ip_next(exec_ip_next),
    .exec_jump(exec_jump),
    .jump_ip(jump_ip),
    .instr_advance(instr_advance),
    .thread_almost_switched(thread_almost_switched),
    .thread_ip_wr(thread_ip_wr),
    .thread_ip_wr_num(thread_ip_wr_num),
    .thread_ip_wr_data(thread_ip_wr_data),
    .thread_ip_wr_ready(thread_ip_wr_ready),
    .reload(reload),
    .invalidate(invalidate),
    .ip_curr(ip_curr),
    .thread_num(thread_num),
    .thread_num_exec(thread_num_exec),
    .thread_active(thread_active),
    .idle_cycles(idle_cycles)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every reload pulse must match the oldest expected (thread, IP) pair
  always @(negedge CLK) begin
    if (!reset && reload === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_reload", {23'd0, ip_curr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_reload_thread", {30'd0, thread_num}, {30'd0, e.tn});
        chk("sb_reload_ip", {23'd0, ip_curr}, {23'd0, e.ip});
      end
    end
  end

  initial begin
    reset = 1'b1;
    thread_ready = 4'b0000;
    exec_switch = 1'b0;
    exec_ip_next = '0;
    exec_jump = 1'b0;
    jump_ip = '0;
    instr_advance = 1'b0;
    thread_almost_switched = 1'b0;
    thread_ip_wr = 1'b0;
    thread_ip_wr_num = '0;
    thread_ip_wr_data = '0;

    // Establish known RAM contents (all zero) while in reset
    for (int i = 0; i < 4; i++) begin
      thread_ip_wr = 1'b1;
      thread_ip_wr_num = 2'(i);
      thread_ip_wr_data = 9'h000;
      tick();
    end
    thread_ip_wr = 1'b0;
    tick();

    chk("rst_reload", {31'd0, reload}, 32'd0);
    chk("rst_invalidate", {31'd0, invalidate}, 32'd0);
    chk("rst_ip_curr", {23'd0, ip_curr}, 32'd0);
    chk("rst_thread_num", {30'd0, thread_num}, 32'd0);
    chk("rst_thread_num_exec", {30'd0, thread_num_exec}, 32'd0);
    chk("rst_thread_active", {31'd0, thread_active}, 32'd0);
    chk("rst_idle_cycles", {16'd0, idle_cycles}, 32'd0);
    chk("rst_wr_ready", {31'd0, thread_ip_wr_ready}, 32'd1);

    // Idle: no thread ready for 10 cycles
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("idle_not_active", {31'd0, thread_active}, 32'd0);
`ifdef CPU_IDLE_COUNTER_EN
    chk("idle_ge10", {31'd0, (idle_cycles >= 16'd10)}, 32'd1);
`else
    chk("idle_tied0", {16'd0, idle_cycles}, 32'd0);
`endif

    // Cold start on thread 2
    thread_ready = 4'b0100;
    sb.push_back('{tn: 2'd2, ip: 9'h000});
    tick();
    chk("cold_thread_num", {30'd0, thread_num}, 32'd2);
    chk("cold_no_reload_yet", {31'd0, reload}, 32'd0);
    tick();
    chk("cold_reload", {31'd0, reload}, 32'd1);
    chk("cold_active", {31'd0, thread_active}, 32'd1);

    // Advance coincident with reload is ignored, then three advances
    instr_advance = 1'b1;
    tick();
    chk("adv_on_reload", {23'd0, ip_curr}, 32'd0);
    tick(); tick(); tick();
    chk("adv_three", {23'd0, ip_curr}, 32'd3);
    instr_advance = 1'b0;

    // Switch from thread 2 saving 0x05A, external write to thread 1 colliding
    thread_ready = 4'b0101;
    exec_switch = 1'b1;
    exec_ip_next = 9'h05A;
    thread_ip_wr = 1'b1;
    thread_ip_wr_num = 2'd1;
    thread_ip_wr_data = 9'h123;
    #1;
    chk("wr_ready_blocked", {31'd0, thread_ip_wr_ready}, 32'd0);
    sb.push_back('{tn: 2'd0, ip: 9'h000});
    tick();
    exec_switch = 1'b0;
    chk("sw_invalidate", {31'd0, invalidate}, 32'd1);
    chk("sw_inactive", {31'd0, thread_active}, 32'd0);
    chk("wr_ready_after", {31'd0, thread_ip_wr_ready}, 32'd1);
    tick();
    thread_ip_wr = 1'b0;
    chk("sw_thread_num", {30'd0, thread_num}, 32'd0);
    chk("sw_inval_cleared", {31'd0, invalidate}, 32'd0);
    tick();
    chk("sw_reload", {31'd0, reload}, 32'd1);

    // Jump and switch together: switch wins, jump target discarded
    thread_ready = 4'b0010;
    exec_switch = 1'b1;
    exec_ip_next = 9'h077;
    exec_jump = 1'b1;
    jump_ip = 9'h1FF;
    sb.push_back('{tn: 2'd1, ip: 9'h123});
    tick();
    exec_switch = 1'b0;
    exec_jump = 1'b0;
    chk("jsw_invalidate", {31'd0, invalidate}, 32'd1);
    chk("jsw_ip_not_jumped", {23'd0, ip_curr}, 32'd0);
    tick();
    chk("jsw_thread_num", {30'd0, thread_num}, 32'd1);
    tick();
    tick();
    chk("jsw_ip_hold", {23'd0, ip_curr}, 32'h123);

    // Jump alone; advances during invalidate and reload are ignored
    exec_jump = 1'b1;
    jump_ip = 9'h1FF;
    sb.push_back('{tn: 2'd1, ip: 9'h1FF});
    tick();
    exec_jump = 1'b0;
    instr_advance = 1'b1;
    chk("jmp_invalidate", {31'd0, invalidate}, 32'd1);
    chk("jmp_ip", {23'd0, ip_curr}, 32'h1FF);
    tick();
    chk("jmp_reload", {31'd0, reload}, 32'd1);
    tick();
    chk("jmp_ip_after_reload", {23'd0, ip_curr}, 32'h1FF);
    tick();
    chk("jmp_wrap", {23'd0, ip_curr}, 32'd0);
    instr_advance = 1'b0;

    // Return to thread 2 restores its saved IP
    thread_ready = 4'b0100;
    exec_switch = 1'b1;
    exec_ip_next = 9'h0AB;
    sb.push_back('{tn: 2'd2, ip: 9'h05A});
    tick();
    exec_switch = 1'b0;
    tick();
    tick();
    chk("ret_thread_num", {30'd0, thread_num}, 32'd2);

    // Exec-stage retiming
    chk("exec_before", {30'd0, thread_num_exec}, 32'd0);
    thread_almost_switched = 1'b1;
    tick();
    thread_almost_switched = 1'b0;
    chk("exec_after", {30'd0, thread_num_exec}, 32'd2);

    // Write the running thread's slot, then reset mid-RUN without a save
    thread_ip_wr = 1'b1;
    thread_ip_wr_num = 2'd2;
    thread_ip_wr_data = 9'h1AA;
    tick();
    thread_ip_wr = 1'b0;
    chk("run_ip_unaffected", {23'd0, ip_curr}, 32'h05A);
    reset = 1'b1;
    thread_ready = 4'b0101;
    tick();
    chk("rst2_thread_num", {30'd0, thread_num}, 32'd0);
    chk("rst2_exec", {30'd0, thread_num_exec}, 32'd0);
    chk("rst2_active", {31'd0, thread_active}, 32'd0);
    chk("rst2_ip", {23'd0, ip_curr}, 32'd0);

    // First pick after reset scans from thread 0
    reset = 1'b0;
    sb.push_back('{tn: 2'd0, ip: 9'h077});
    tick();
    chk("rst2_pick0", {30'd0, thread_num}, 32'd0);
    tick();
    thread_ready = 4'b0100;
    exec_switch = 1'b1;
    exec_ip_next = 9'h011;
    sb.push_back('{tn: 2'd2, ip: 9'h1AA});
    tick();
    exec_switch = 1'b0;
    tick();
    tick();
    tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
